// File: rtl/mmu_map_ram_ctl_if.sv
// Host (blitter/debug) access port of the MMU map RAM controller.
//   host_req   : request, held high until host_ack
//   host_we    : 1 = write, 0 = read; stable while host_req=1
//   host_addr  : map address; stable while host_req=1
//   host_wdata : write data; stable while host_req=1
//   host_ack   : single-cycle completion pulse
//   host_rdata : read data, valid in the host_ack cycle
interface mmu_map_ram_ctl_if #(
  parameter int ADDR_W = 8
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;
  logic [7:0]        host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );
endinterface

// File: rtl/mmu_map_ram_ctl.sv
// MMU map RAM controller.
// Owns the synchronous map RAM (1-cycle read latency) and shares it between
// the CPU and a host port. After reset it writes an identity mapping into
// every entry, then hands free RAM cycles to the host via req/ack.
// Ports:
//   CLKX4, RESET            clock (4x E), synchronous active-high reset
//   cpu_busy/addr/we/wdata  CPU owns the RAM whenever cpu_busy=1
//   cpu_rdata               map data to CPU (straight from the RAM)
//   host                    host req/ack port (slave side)
//   ready                   fill complete, map valid
//   ram_addr/we/wdata/rdata physical map RAM port
module mmu_map_ram_ctl #(
  parameter int         ADDR_W  = 8,
  parameter bit         INIT_EN = 1'b1,
  parameter logic [1:0] INIT_CS = 2'b10
) (
  input  logic                CLKX4,
  input  logic                RESET,
  input  logic                cpu_busy,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic                cpu_we,
  input  logic [7:0]          cpu_wdata,
  output logic [7:0]          cpu_rdata,
  mmu_map_ram_ctl_if.slave    host,
  output logic                ready,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [7:0]          ram_wdata,
  input  logic [7:0]          ram_rdata
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_HWAIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fill_cnt;
  logic [7:0]        fill_val;
  logic              fill_last;
  logic              fill_wr;
  logic              grant;
  logic              hwe_q;
  logic              ack_q;
  logic [7:0]        rdata_q;

  assign cpu_rdata       = ram_rdata;
  assign host.host_ack   = ack_q;
  assign host.host_rdata = rdata_q;

  // Identity map: slot a[2:0] -> A15:13, chip select in [7:6].
  assign fill_val  = {INIT_CS, fill_cnt[0], 3'b000, fill_cnt[2:1]};
  assign fill_last = &fill_cnt;

  always_comb begin
    state_nxt = state;
    fill_wr   = 1'b0;
    grant     = 1'b0;
    // CPU path is the default; fill/host only take over on cpu_busy=0.
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_busy & cpu_we;
    if (!RESET) begin
      case (state)
        S_INIT: if (!cpu_busy) begin
          fill_wr = 1'b1;
          if (fill_last) state_nxt = S_IDLE;
        end
        // No grant in the ack cycle: the host still holds req there, and a
        // second grant would duplicate the access it is just retiring.
        S_IDLE: if (host.host_req && !cpu_busy && !ack_q) begin
          grant     = 1'b1;
          state_nxt = S_HWAIT;
        end
        S_HWAIT: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
    if (fill_wr) begin
      ram_addr  = fill_cnt;
      ram_we    = 1'b1;
      ram_wdata = fill_val;
    end else if (grant) begin
      ram_addr  = host.host_addr;
      ram_we    = host.host_we;
      ram_wdata = host.host_wdata;
    end
  end

  always_ff @(posedge CLKX4) begin
    if (RESET) begin
      state    <= INIT_EN ? S_INIT : S_IDLE;
      fill_cnt <= '0;
      ready    <= !INIT_EN;
      ack_q    <= 1'b0;
      rdata_q  <= 8'h00;
      hwe_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= (state == S_HWAIT);
      if (fill_wr) fill_cnt <= fill_cnt + 1'b1;
      if (fill_wr && fill_last) ready <= 1'b1;
      if (grant) hwe_q <= host.host_we;
      // RAM latched the host address on the grant edge, so ram_rdata here
      // belongs to the host even if the CPU drives the RAM this cycle.
      if (state == S_HWAIT && !hwe_q) rdata_q <= ram_rdata;
    end
  end

endmodule
